// File: rtl/mem_port_arbiter.sv
// Purpose: shares one 32-bit memory master port between fetch (s0) and data (s1) requesters.
// Latency: 1 cycle to arbitrate, then BUSY until m_ack_i; a 1-cycle IDLE bubble separates transactions.
// Backpressure: requesters hold valid until their ack; the memory stalls the owner by withholding m_ack_i.
// Optional: define ARB_TIMEOUT_EN to abort a BUSY cycle after TIMEOUT_CYCLES without m_ack_i.
module mem_port_arbiter #(
  parameter bit          ARB_RR         = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] s0_adr_i,
  input  logic        s0_valid_i,
  output logic [31:0] s0_dat_o,
  output logic        s0_ack_o,
  output logic        s0_err_o,
  input  logic [31:0] s1_adr_i,
  input  logic [31:0] s1_dat_i,
  input  logic        s1_we_i,
  input  logic [3:0]  s1_sel_i,
  input  logic        s1_valid_i,
  output logic [31:0] s1_dat_o,
  output logic        s1_ack_o,
  output logic        s1_err_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_valid_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Request fields presented towards memory by one requester.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  state_e state_q, state_d;
  logic   owner_q, owner_d;   // 0 = s0 fetch, 1 = s1 data
  logic   last_q, last_d;     // requester served most recently
  logic   grant;
  logic   busy;
  logic   done;
  logic   to_hit;
  req_t   s0_req, s1_req, own_req;

  assign busy = (state_q == ST_BUSY);

  // Fetch is always a full-word read; it has no write data.
  assign s0_req = '{adr: s0_adr_i, dat: 32'h0, we: 1'b0, sel: 4'hF};
  assign s1_req = '{adr: s1_adr_i, dat: s1_dat_i, we: s1_we_i, sel: s1_sel_i};

`ifdef ARB_TIMEOUT_EN
  logic [7:0] to_cnt_q;

  // Count BUSY cycles without an ack; held at zero while IDLE so every grant starts fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= 8'h00;
    end else if (!busy) begin
      to_cnt_q <= 8'h00;
    end else if (!m_ack_i) begin
      to_cnt_q <= to_cnt_q + 8'h01;
    end
  end

  // A real ack in the final cycle takes precedence over the abort.
  assign to_hit = busy && !m_ack_i && (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign done = busy && (m_ack_i || to_hit);

  // Pick the next owner: fixed priority favours s1, round-robin hands ties to whoever was not served last.
  always_comb begin
    grant = s1_valid_i;
    if (ARB_RR && s0_valid_i && s1_valid_i) begin
      grant = ~last_q;
    end
  end

  // State, owner and last-served registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: grant from IDLE, release to IDLE on completion so the old owner's valid is never re-sampled in its ack cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_valid_i || s1_valid_i) begin
          owner_d = grant;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory side: request qualified by state alone, fields muxed from the current owner.
  always_comb begin
    own_req   = owner_q ? s1_req : s0_req;
    m_valid_o = busy;
    m_adr_o   = own_req.adr;
    m_dat_o   = own_req.dat;
    m_we_o    = own_req.we;
    m_sel_o   = own_req.sel;
  end

  // Requester side: completion goes only to the owner; aborted reads return zero data.
  always_comb begin
    s0_ack_o = done && !owner_q;
    s1_ack_o = done && owner_q;
    s0_err_o = to_hit && !owner_q;
    s1_err_o = to_hit && owner_q;
    s0_dat_o = (to_hit && !owner_q) ? 32'h0 : m_dat_i;
    s1_dat_o = (to_hit && owner_q) ? 32'h0 : m_dat_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority and a round-robin instance share one stimulus stream.
// A transaction-level model predicts every output each cycle; directed phases pin literal values.
module tb_mem_port_arbiter;

  localparam int TOUT = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] s0_adr_i;
  logic        s0_valid_i;
  logic [31:0] s1_adr_i;
  logic [31:0] s1_dat_i;
  logic        s1_we_i;
  logic [3:0]  s1_sel_i;
  logic        s1_valid_i;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  logic [1:0][31:0] s0_dat_w, s1_dat_w, m_adr_w, m_dat_w;
  logic [1:0][3:0]  m_sel_w;
  logic [1:0]       s0_ack_w, s0_err_w, s1_ack_w, s1_err_w, m_we_w, m_valid_w;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance (0 = fixed priority, 1 = round-robin).
  bit mb[2];   // a transaction is in flight
  bit mo[2];   // which requester it belongs to
  bit ml[2];   // requester served last
  int mw[2];   // cycles the transaction has waited for an ack
  bit gq_fix[$];
  bit gq_rr[$];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ARB_RR(1'b0), .TIMEOUT_CYCLES(TOUT)) u_fix (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_adr_i(s0_adr_i), .s0_valid_i(s0_valid_i), .s0_dat_o(s0_dat_w[0]),
    .s0_ack_o(s0_ack_w[0]), .s0_err_o(s0_err_w[0]),
    .s1_adr_i(s1_adr_i), .s1_dat_i(s1_dat_i), .s1_we_i(s1_we_i), .s1_sel_i(s1_sel_i),
    .s1_valid_i(s1_valid_i), .s1_dat_o(s1_dat_w[0]), .s1_ack_o(s1_ack_w[0]), .s1_err_o(s1_err_w[0]),
    .m_adr_o(m_adr_w[0]), .m_dat_o(m_dat_w[0]), .m_we_o(m_we_w[0]), .m_sel_o(m_sel_w[0]),
    .m_valid_o(m_valid_w[0]), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  mem_port_arbiter #(.ARB_RR(1'b1), .TIMEOUT_CYCLES(TOUT)) u_rr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_adr_i(s0_adr_i), .s0_valid_i(s0_valid_i), .s0_dat_o(s0_dat_w[1]),
    .s0_ack_o(s0_ack_w[1]), .s0_err_o(s0_err_w[1]),
    .s1_adr_i(s1_adr_i), .s1_dat_i(s1_dat_i), .s1_we_i(s1_we_i), .s1_sel_i(s1_sel_i),
    .s1_valid_i(s1_valid_i), .s1_dat_o(s1_dat_w[1]), .s1_ack_o(s1_ack_w[1]), .s1_err_o(s1_err_w[1]),
    .m_adr_o(m_adr_w[1]), .m_dat_o(m_dat_w[1]), .m_we_o(m_we_w[1]), .m_sel_o(m_sel_w[1]),
    .m_valid_o(m_valid_w[1]), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  // One cycle of the reference: predict outputs from the rules, then advance the transaction record.
  task automatic model_step(input int k);
    string t;
    bit    to, done, g;
    t = (k == 0) ? "fix" : "rr";
    if (!rst_ni) begin
      mb[k] = 1'b0; mo[k] = 1'b0; ml[k] = 1'b0; mw[k] = 0;
      chk({t, ".rst.m_valid"}, m_valid_w[k], 0);
      chk({t, ".rst.s0_ack"}, s0_ack_w[k], 0);
      chk({t, ".rst.s1_ack"}, s1_ack_w[k], 0);
      chk({t, ".rst.errs"}, {s0_err_w[k], s1_err_w[k]}, 0);
      return;
    end
    to   = TO_EN && mb[k] && !m_ack_i && (mw[k] == TOUT - 1);
    done = mb[k] && (m_ack_i || to);
    chk({t, ".m_valid"}, m_valid_w[k], mb[k]);
    if (mb[k]) begin
      if (mo[k]) begin
        chk({t, ".m_adr"}, m_adr_w[k], s1_adr_i);
        chk({t, ".m_dat"}, m_dat_w[k], s1_dat_i);
        chk({t, ".m_we"}, m_we_w[k], s1_we_i);
        chk({t, ".m_sel"}, m_sel_w[k], s1_sel_i);
      end else begin
        chk({t, ".m_adr"}, m_adr_w[k], s0_adr_i);
        chk({t, ".m_we"}, m_we_w[k], 0);
        chk({t, ".m_sel"}, m_sel_w[k], 4'hF);
      end
    end
    chk({t, ".s0_ack"}, s0_ack_w[k], done && !mo[k]);
    chk({t, ".s1_ack"}, s1_ack_w[k], done && mo[k]);
    chk({t, ".s0_err"}, s0_err_w[k], to && !mo[k]);
    chk({t, ".s1_err"}, s1_err_w[k], to && mo[k]);
    if (done) begin
      if (mo[k]) chk({t, ".s1_dat"}, s1_dat_w[k], to ? 32'h0 : m_dat_i);
      else       chk({t, ".s0_dat"}, s0_dat_w[k], to ? 32'h0 : m_dat_i);
    end
    if (!mb[k]) begin
      if (s0_valid_i || s1_valid_i) begin
        if (k == 1 && s0_valid_i && s1_valid_i) g = !ml[k];
        else                                   g = s1_valid_i;
        mb[k] = 1'b1; mo[k] = g; mw[k] = 0;
        if (k == 0) gq_fix.push_back(g);
        else        gq_rr.push_back(g);
      end
    end else if (done) begin
      mb[k] = 1'b0;
      ml[k] = mo[k];
    end else begin
      mw[k]++;
    end
  endtask

  always @(negedge clk_i) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         a0, a1;
    logic [3:0] rr_pat;
    rst_ni = 1'b0; s0_adr_i = 32'h0; s0_valid_i = 1'b1;
    s1_adr_i = 32'h0; s1_dat_i = 32'h0; s1_we_i = 1'b0; s1_sel_i = 4'h0; s1_valid_i = 1'b0;
    m_dat_i = 32'h0; m_ack_i = 1'b0;

    // Reset held with a fetch pending: memory port stays idle.
    at_neg();
    for (int k = 0; k < 2; k++) chk("reset.m_valid", m_valid_w[k], 0);

    // Single fetch, memory acks in the second BUSY cycle.
    tick(); rst_ni = 1'b1; s0_adr_i = 32'h100;
    at_neg();
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("fetch.m_valid", m_valid_w[k], 1);
      chk("fetch.m_adr", m_adr_w[k], 32'h100);
      chk("fetch.early_ack", s0_ack_w[k], 0);
    end
    tick(); m_ack_i = 1'b1; m_dat_i = 32'h12345678;
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("fetch.s0_ack", s0_ack_w[k], 1);
      chk("fetch.s0_dat", s0_dat_w[k], 32'h12345678);
      chk("fetch.s1_ack", s1_ack_w[k], 0);
    end
    tick(); m_ack_i = 1'b0; s0_valid_i = 1'b0;
    at_neg();
    for (int k = 0; k < 2; k++) chk("fetch.ack_pulse", s0_ack_w[k], 0);

    // Both requesters valid, zero-wait memory: fixed starves s0, round-robin alternates.
    tick(); s0_valid_i = 1'b1; s1_valid_i = 1'b1; m_ack_i = 1'b1;
    gq_fix.delete(); gq_rr.delete();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("arb.bubble_fix", m_valid_w[0], 0);
      chk("arb.bubble_rr", m_valid_w[1], 0);
      at_neg();
      chk("arb.fix_s1_ack", s1_ack_w[0], 1);
      chk("arb.fix_s0_ack", s0_ack_w[0], 0);
      chk("arb.rr_s1_ack", s1_ack_w[1], (i % 2) == 0);
      chk("arb.rr_s0_ack", s0_ack_w[1], (i % 2) == 1);
    end
    rr_pat = 4'b0101;
    chk("model.gq_fix_n", gq_fix.size(), 4);
    chk("model.gq_rr_n", gq_rr.size(), 4);
    for (int i = 0; i < gq_fix.size() && i < 4; i++) chk("model.gq_fix", gq_fix[i], 1);
    for (int i = 0; i < gq_rr.size() && i < 4; i++) chk("model.gq_rr", gq_rr[i], rr_pat[i]);
    tick(); s1_valid_i = 1'b0;
    at_neg();
    at_neg();
    for (int k = 0; k < 2; k++) chk("arb.s0_after_drop", s0_ack_w[k], 1);
    tick(); s0_valid_i = 1'b0; m_ack_i = 1'b0;

    // Data write passthrough.
    s1_adr_i = 32'h2000_0004; s1_dat_i = 32'hCAFEBABE; s1_we_i = 1'b1; s1_sel_i = 4'b0011; s1_valid_i = 1'b1;
    at_neg();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("wr.m_adr", m_adr_w[k], 32'h2000_0004);
      chk("wr.m_dat", m_dat_w[k], 32'hCAFEBABE);
      chk("wr.m_we", m_we_w[k], 1);
      chk("wr.m_sel", m_sel_w[k], 4'b0011);
      chk("wr.no_ack_yet", s1_ack_w[k], 0);
    end
    tick(); m_ack_i = 1'b1;
    at_neg();
    for (int k = 0; k < 2; k++) chk("wr.s1_ack", s1_ack_w[k], 1);
    tick(); m_ack_i = 1'b0; s1_valid_i = 1'b0; s1_we_i = 1'b0;

    // Spurious ack while idle.
    m_ack_i = 1'b1;
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("spur.acks", {s0_ack_w[k], s1_ack_w[k]}, 0);
      chk("spur.m_valid", m_valid_w[k], 0);
    end
    tick(); m_ack_i = 1'b0;
    at_neg();
    for (int k = 0; k < 2; k++) chk("spur.stay_idle", m_valid_w[k], 0);

    // Asynchronous reset in the middle of a BUSY cycle.
    tick(); s0_valid_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("arst.busy", m_valid_w[k], 1);
    #2 rst_ni = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("arst.m_valid_drop", m_valid_w[k], 0);
    tick(); rst_ni = 1'b1; s0_valid_i = 1'b0;
    at_neg();
    for (int k = 0; k < 2; k++) chk("arst.idle", m_valid_w[k], 0);

`ifdef ARB_TIMEOUT_EN
    // Memory never acks: abort in the fourth BUSY cycle, late ack ignored.
    tick(); m_dat_i = 32'hDEADBEEF; s0_valid_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      at_neg();
      for (int k = 0; k < 2; k++) begin
        chk("to.s0_ack", s0_ack_w[k], c == 4);
        chk("to.s0_err", s0_err_w[k], c == 4);
        if (c == 4) chk("to.s0_dat", s0_dat_w[k], 32'h0);
      end
    end
    tick(); s0_valid_i = 1'b0; m_ack_i = 1'b1;
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("to.idle", m_valid_w[k], 0);
      chk("to.late_ack", s0_ack_w[k], 0);
    end
    // Ack arriving in the abort cycle wins.
    tick(); m_ack_i = 1'b0; s0_valid_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) m_ack_i = 1'b1;
      at_neg();
      for (int k = 0; k < 2; k++) chk("to_ack.s0_ack", s0_ack_w[k], c == 4);
    end
    for (int k = 0; k < 2; k++) begin
      chk("to_ack.s0_err", s0_err_w[k], 0);
      chk("to_ack.s0_dat", s0_dat_w[k], 32'hDEADBEEF);
    end
    tick(); s0_valid_i = 1'b0; m_ack_i = 1'b0;
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      at_neg();
      a0 = s0_ack_w[0];
      a1 = s1_ack_w[0];
      tick();
      if (a0 || !s0_valid_i) begin
        s0_valid_i = 1'($urandom % 2);
        s0_adr_i   = $urandom;
      end else if ($urandom % 20 == 0) begin
        s0_valid_i = 1'b0;
      end
      if (a1 || !s1_valid_i) begin
        s1_valid_i = 1'($urandom % 2);
        s1_adr_i   = $urandom;
        s1_dat_i   = $urandom;
        s1_we_i    = 1'($urandom % 2);
        s1_sel_i   = 4'($urandom);
      end else if ($urandom % 20 == 0) begin
        s1_valid_i = 1'b0;
      end
      m_ack_i = ($urandom % 5) < 2;
      m_dat_i = $urandom;
    end
    at_neg();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
